// File: rtl/float_to_fixed_conv_p.sv
// Float-to-fixed converter: decodes an IEEE-style float, aligns the mantissa one bit per
// clock, then rounds (truncate or nearest-even) and saturates into two's-complement fixed point.
module float_to_fixed_conv_p #(
    parameter int EW     = 8,
    parameter int MW     = 23,
    parameter int FIX_W  = 32,
    parameter int FRAC_W = 26
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RST_FSM,
    input  logic             START,
    input  logic             RND_MODE,
    input  logic [EW+MW:0]   FLOAT,
    output logic             BUSY,
    output logic             ACK,
    output logic [FIX_W-1:0] FIXED,
    output logic             OVF,
    output logic             INV
);

    localparam int BIAS     = (1 << (EW - 1)) - 1;
    localparam int INT_BITS = FIX_W - 1 - FRAC_W;
    localparam int CNT_MAX  = MW + 3;
    localparam int CNT_W    = $clog2(FIX_W + MW + 4);

    localparam logic [FIX_W-1:0] SAT_POS     = {1'b0, {(FIX_W-1){1'b1}}};
    localparam logic [FIX_W-1:0] SAT_NEG     = {1'b1, {(FIX_W-1){1'b0}}};
    localparam logic [FIX_W:0]   MAG_POS_MAX = {2'b00, {(FIX_W-1){1'b1}}};
    localparam logic [FIX_W:0]   MAG_NEG_MAX = {2'b01, {(FIX_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [EW+MW:0]     float_q, float_d;
    logic               rnd_q, rnd_d;
    logic [FIX_W:0]     mag_q, mag_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               left_q, left_d;
    logic [FIX_W-1:0]   fixed_q, fixed_d;
    logic               ovf_q, ovf_d;
    logic               inv_q, inv_d;

    logic               sign_w;
    logic [EW-1:0]      exp_w;
    logic [MW-1:0]      man_w;
    int                 e_val;
    int                 sh_val;
    int                 sh_abs;
    logic [CNT_W-1:0]   cnt_init;
    logic [FIX_W:0]     mag_init;
    logic [FIX_W-1:0]   sat_val;
    logic               round_inc;
    logic [FIX_W:0]     mag_rnd;

    // Field decode, alignment distance and the rounding increment.
    always_comb begin
        sign_w   = float_q[EW+MW];
        exp_w    = float_q[EW+MW-1:MW];
        man_w    = float_q[MW-1:0];
        e_val    = int'(exp_w) - BIAS;
        sh_val   = e_val + FRAC_W - MW;
        sh_abs   = (sh_val < 0) ? -sh_val : sh_val;
        if (sh_val < 0 && sh_abs > CNT_MAX) begin
            sh_abs = CNT_MAX;
        end
        cnt_init  = CNT_W'(sh_abs);
        mag_init  = {{(FIX_W-MW){1'b0}}, 1'b1, man_w};
        sat_val   = sign_w ? SAT_NEG : SAT_POS;
        round_inc = rnd_q & guard_q & (sticky_q | mag_q[0]);
        mag_rnd   = mag_q + {{FIX_W{1'b0}}, round_inc};
    end

    always_comb begin
        state_d  = state_q;
        float_d  = float_q;
        rnd_d    = rnd_q;
        mag_d    = mag_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        fixed_d  = fixed_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;

        if (RST_FSM) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        float_d = FLOAT;
                        rnd_d   = RND_MODE;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    mag_d    = mag_init;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    cnt_d    = cnt_init;
                    left_d   = (sh_val > 0);
                    state_d  = S_DONE;
                    if (&exp_w) begin
                        fixed_d = (man_w != '0) ? '0 : sat_val;
                        ovf_d   = (man_w == '0);
                        inv_d   = (man_w != '0);
                    end else if (exp_w == '0) begin
                        // Zero and denormals are flushed to zero.
                        fixed_d = '0;
                        ovf_d   = 1'b0;
                        inv_d   = 1'b0;
                    end else if (e_val > INT_BITS) begin
                        fixed_d = sat_val;
                        ovf_d   = 1'b1;
                        inv_d   = 1'b0;
                    end else if (e_val == INT_BITS) begin
                        // Only -2^INT_BITS exactly is representable at this exponent.
                        fixed_d = sat_val;
                        ovf_d   = !(sign_w && man_w == '0);
                        inv_d   = 1'b0;
                    end else begin
                        state_d = (cnt_init != '0) ? S_SHIFT : S_ROUND;
                    end
                end
                S_SHIFT: begin
                    if (left_q) begin
                        mag_d = mag_q << 1;
                    end else begin
                        sticky_d = sticky_q | guard_q;
                        guard_d  = mag_q[0];
                        mag_d    = mag_q >> 1;
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_ROUND;
                    end
                end
                S_ROUND: begin
                    inv_d   = 1'b0;
                    state_d = S_DONE;
                    if ((!sign_w && mag_rnd > MAG_POS_MAX) || (sign_w && mag_rnd > MAG_NEG_MAX)) begin
                        fixed_d = sat_val;
                        ovf_d   = 1'b1;
                    end else begin
                        fixed_d = sign_w ? (FIX_W'(0) - mag_rnd[FIX_W-1:0]) : mag_rnd[FIX_W-1:0];
                        ovf_d   = 1'b0;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            float_q  <= '0;
            rnd_q    <= 1'b0;
            mag_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            fixed_q  <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            float_q  <= float_d;
            rnd_q    <= rnd_d;
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            fixed_q  <= fixed_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    assign BUSY  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign ACK   = (state_q == S_DONE);
    assign FIXED = fixed_q;
    assign OVF   = ovf_q;
    assign INV   = inv_q;

endmodule
